attack_scheduler: RTL
=====================

# attack_scheduler

Shared leaper-attack sequencer for the move generator and check detector. The block owns one combinational leaper-attack unit and arbitrates it round-robin between two requesters. For each granted request it steps the unit through knight, king and pawn passes for the requested side and ORs the results into a 64-bit attack map. The map is returned with a one-cycle done pulse. It sits between the board-state registers and the legality/check logic.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request per requester (bit 0 = move generator, bit 1 = check detector); level, held until done
- req_side  in  2  side per requester (0 = white, 1 = black)
- w_pawns, w_knights, w_king  in  64 each  white bitboards; bit = rank*8 + file, file 0 = bit 0 of each byte
- b_pawns, b_knights, b_king  in  64 each  black bitboards; stable while busy
- busy  out  1  FSM not IDLE
- grant_id  out  1  requester being served; valid while busy
- done  out  1  one-cycle pulse, result valid
- done_id  out  1  requester owning the result, valid with done
- attack_map  out  64  accumulated attacks; holds last value until the next grant

## Operation
- States: IDLE, KNIGHT, KING, PAWN, DONE.
- IDLE:
  - If any req bit is set, arbitrate, latch the winner's id and side, clear the accumulator, and go to KNIGHT.
  - Otherwise stay in IDLE.
- Arbitration:
  - Round-robin on a last-grant pointer.
  - On a tie, the requester that is not the pointer wins.
  - The pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates on each grant.
- KNIGHT:
  - Shared unit in knight mode on the side's knights.
  - Compute l1/r1 = one-file shifts, l2/r2 = two-file shifts, each masked against file wrap.
  - attack = h1<<16 | h1>>16 | h2<<8 | h2>>8, where h1 = l1|r1 and h2 = l2|r2.
  - OR into the accumulator; go to KING.
- KING:
  - Shared unit in king mode.
  - h = (k>>1 & 0x7f7f…) | (k<<1 & 0xfefe…); k' = k | h.
  - attack = h | k'<<8 | k'>>8.
  - OR into the accumulator; go to PAWN.
- PAWN:
  - White: (p<<9 & 0xfefe…) | (p<<7 & 0x7f7f…).
  - Black: (p>>7 & 0xfefe…) | (p>>9 & 0x7f7f…).
  - OR into the accumulator; go to DONE.
- DONE: assert done and done_id; attack_map = accumulator; go to IDLE.
- Arbitration happens only in IDLE. req is ignored in all other states.
- req dropped mid-sequence: the sequence completes and done is still issued. The requester discards the result.
- The requester clears req on the edge at which it observes done. If req is still high in IDLE, it is a new request.
- Empty bitboards are legal and contribute 0. All shifts are 64-bit; bits shifted past bit 0 or bit 63 are discarded.
- Reset mid-sequence returns the block to IDLE immediately. Any partial result is lost.

## Timing
- Reset values: busy 0, grant_id 0, done 0, done_id 0, attack_map 0, pointer 1, state IDLE.
- Request seen high at edge N (in IDLE):
  - KNIGHT in cycle N+1, KING in N+2, PAWN in N+3.
  - done high in cycle N+4; IDLE in N+5.
  - Latency: 4 cycles from the accepting edge to done.
- Throughput: one request per 5 cycles.
- busy is high from N+1 through N+4 inclusive.
- attack_map updates at the edge entering DONE and is stable from then until the next DONE.
- All outputs are registered; no combinational path from input to output.

## Configuration
- ATTACK_SCHED_PAWN_EN:
  - Defined: PAWN state present; latency 4, throughput one per 5 cycles.
  - Undefined: PAWN state and pawn logic are removed. KING goes directly to DONE, giving latency 3 and throughput one per 4 cycles. The pawn bitboard inputs remain as ports and are ignored.

## Test plan
- White, requester 0 only; w_knights = 0x1, w_king = 0x8000000000000000, w_pawns = 0x100 -> done with done_id 0 four cycles after acceptance; attack_map = 0x40C0000000020400.
- Black, requester 1; b_pawns = 0x0002000000000000, other boards 0 -> attack_map = 0x0000050000000000; a corner knight on bit 63 alone gives 0x0020400000000000.
- Both requesters raised every cycle from reset -> grants alternate 0,1,0,1; each done_id matches its grant; 5-cycle spacing between done pulses.
- Reset asserted in the KING cycle -> all outputs 0 asynchronously; after release, the first tie grants requester 0.
- Requester drops req in the KNIGHT cycle -> done still pulses at N+4; the next IDLE with req = 0 stays IDLE with busy = 0.
- ATTACK_SCHED_PAWN_EN undefined, same stimulus as the first scenario -> done at N+3; attack_map = 0x40C0000000020400 (the pawn bit 17 coincides with a knight bit); w_pawns = 0x8000 alone -> attack_map = 0.

Source files
------------

// File: rtl/attack_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : attack_scheduler
// Brief    : Round-robin shared leaper-attack sequencer (knight/king/pawn passes
//            OR-ed into a 64-bit attack map). Optional pawn pass is enabled by
//            defining ATTACK_SCHED_PAWN_EN.
// Revision : 1.0 - initial release
// ============================================================================

module attack_leaper_unit (
    input  logic [1:0]  mode,
`ifdef ATTACK_SCHED_PAWN_EN
    input  logic        side,
`endif
    input  logic [63:0] board,
    output logic [63:0] attack
);
    localparam logic [1:0]  c_mode_knight = 2'd0;
    localparam logic [1:0]  c_mode_king   = 2'd1;
`ifdef ATTACK_SCHED_PAWN_EN
    localparam logic [1:0]  c_mode_pawn   = 2'd2;
`endif
    localparam logic [63:0] c_not_file_a  = 64'hfefe_fefe_fefe_fefe;
    localparam logic [63:0] c_not_file_h  = 64'h7f7f_7f7f_7f7f_7f7f;
    localparam logic [63:0] c_not_file_ab = 64'hfcfc_fcfc_fcfc_fcfc;
    localparam logic [63:0] c_not_file_gh = 64'h3f3f_3f3f_3f3f_3f3f;

    logic [63:0] w_l1, w_r1, w_l2, w_r2, w_h1, w_h2, w_knight_att;
    logic [63:0] w_king_h, w_king_ext, w_king_att;

    // Masks drop squares that would wrap onto the adjacent rank.
    assign w_l1 = (board >> 1) & c_not_file_h;
    assign w_r1 = (board << 1) & c_not_file_a;
    assign w_l2 = (board >> 2) & c_not_file_gh;
    assign w_r2 = (board << 2) & c_not_file_ab;
    assign w_h1 = w_l1 | w_r1;
    assign w_h2 = w_l2 | w_r2;
    assign w_knight_att = (w_h1 << 16) | (w_h1 >> 16) | (w_h2 << 8) | (w_h2 >> 8);

    assign w_king_h   = ((board >> 1) & c_not_file_h) | ((board << 1) & c_not_file_a);
    assign w_king_ext = board | w_king_h;
    assign w_king_att = w_king_h | (w_king_ext << 8) | (w_king_ext >> 8);

`ifdef ATTACK_SCHED_PAWN_EN
    logic [63:0] w_pawn_att;
    assign w_pawn_att = side ? (((board >> 7) & c_not_file_a) | ((board >> 9) & c_not_file_h))
                             : (((board << 9) & c_not_file_a) | ((board << 7) & c_not_file_h));
`endif

    always_comb begin
        attack = '0;
        case (mode)
            c_mode_knight: attack = w_knight_att;
            c_mode_king:   attack = w_king_att;
`ifdef ATTACK_SCHED_PAWN_EN
            c_mode_pawn:   attack = w_pawn_att;
`endif
            default:       attack = '0;
        endcase
    end
endmodule

module attack_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  req_side,
    input  logic [63:0] w_pawns,
    input  logic [63:0] w_knights,
    input  logic [63:0] w_king,
    input  logic [63:0] b_pawns,
    input  logic [63:0] b_knights,
    input  logic [63:0] b_king,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        done_id,
    output logic [63:0] attack_map
);
    localparam logic [1:0] c_mode_knight = 2'd0;
    localparam logic [1:0] c_mode_king   = 2'd1;
`ifdef ATTACK_SCHED_PAWN_EN
    localparam logic [1:0] c_mode_pawn   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KNIGHT = 3'd1,
        S_KING   = 3'd2,
        S_PAWN   = 3'd3,
        S_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KNIGHT = 3'd1,
        S_KING   = 3'd2,
        S_DONE   = 3'd4
    } state_t;

    logic w_unused_pawns;
    assign w_unused_pawns = ^{w_pawns, b_pawns};
`endif

    state_t      r_state;
    logic        r_ptr;
    logic        r_side;
    logic [63:0] r_acc;

    logic        w_win;
    logic [1:0]  w_unit_mode;
    logic [63:0] w_unit_board;
    logic [63:0] w_unit_attack;
    logic [63:0] w_acc_next;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_win = 1'b0;
        case (req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_ptr;
            default: w_win = 1'b0;
        endcase
    end

    always_comb begin
        w_unit_mode  = c_mode_knight;
        w_unit_board = r_side ? b_knights : w_knights;
        case (r_state)
            S_KING: begin
                w_unit_mode  = c_mode_king;
                w_unit_board = r_side ? b_king : w_king;
            end
`ifdef ATTACK_SCHED_PAWN_EN
            S_PAWN: begin
                w_unit_mode  = c_mode_pawn;
                w_unit_board = r_side ? b_pawns : w_pawns;
            end
`endif
            default: ;
        endcase
    end

    attack_leaper_unit u_unit (
        .mode   (w_unit_mode),
`ifdef ATTACK_SCHED_PAWN_EN
        .side   (r_side),
`endif
        .board  (w_unit_board),
        .attack (w_unit_attack)
    );

    assign w_acc_next = r_acc | w_unit_attack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b1;
            r_side     <= 1'b0;
            r_acc      <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            attack_map <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state  <= S_KNIGHT;
                        busy     <= 1'b1;
                        grant_id <= w_win;
                        r_ptr    <= w_win;
                        r_side   <= req_side[w_win];
                        r_acc    <= '0;
                    end
                end
                S_KNIGHT: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_KING;
                end
`ifdef ATTACK_SCHED_PAWN_EN
                S_KING: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_PAWN;
                end
                S_PAWN: begin
                    r_acc      <= w_acc_next;
                    attack_map <= w_acc_next;
                    done       <= 1'b1;
                    done_id    <= grant_id;
                    r_state    <= S_DONE;
                end
`else
                S_KING: begin
                    r_acc      <= w_acc_next;
                    attack_map <= w_acc_next;
                    done       <= 1'b1;
                    done_id    <= grant_id;
                    r_state    <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
